// File: rtl/cr_xp10_decomp_lz_sym_arb.sv
// Frame-locked arbiter sharing the LZ77 symbol port between the MTF datapath and the FHP debug path.
// Build option: define LZ_ARB_STALL_CNT_EN to add the stall_cycles and frame_hold outputs.
module cr_xp10_decomp_lz_sym_arb #(
    parameter int unsigned SYM_W = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_dbg_en,
    input  logic             mtf_valid,
    input  logic [SYM_W-1:0] mtf_data,
    input  logic             mtf_last,
    output logic             mtf_ready,
    input  logic             dbg_valid,
    input  logic [SYM_W-1:0] dbg_data,
    input  logic             dbg_last,
    output logic             dbg_ready,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] mtf_frames,
    output logic [CNT_W-1:0] dbg_frames,
`ifdef LZ_ARB_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic             frame_hold,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_MTF = 2'd1,
        GNT_DBG = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic rr_last;      // 1 = debug was served last, so MTF wins the next tie
    logic dbg_en_q;
    logic slot_free;
    logic dbg_elig;
    logic mtf_acc;
    logic dbg_acc;
    logic mtf_end;
    logic dbg_end;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: arbitrate only in IDLE, hold the grant until the frame's last beat is taken
    always_comb begin
        state_nxt = state;
        dbg_elig  = dbg_valid & dbg_en_q;
        case (state)
            IDLE: begin
                if (mtf_valid && dbg_elig) begin
                    state_nxt = rr_last ? GNT_MTF : GNT_DBG;
                end else if (mtf_valid) begin
                    state_nxt = GNT_MTF;
                end else if (dbg_elig) begin
                    state_nxt = GNT_DBG;
                end
            end
            GNT_MTF: begin
                if (mtf_end) begin
                    state_nxt = IDLE;
                end
            end
            GNT_DBG: begin
                if (dbg_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake decode from the current grant and output-slot occupancy
    always_comb begin
        slot_free = ~out_valid | out_ready;
        mtf_ready = 1'b0;
        dbg_ready = 1'b0;
        if (state == GNT_MTF) begin
            mtf_ready = slot_free;
        end
        if (state == GNT_DBG) begin
            dbg_ready = slot_free;
        end
        mtf_acc = mtf_ready & mtf_valid;
        dbg_acc = dbg_ready & dbg_valid;
        mtf_end = mtf_acc & mtf_last;
        dbg_end = dbg_acc & dbg_last;
        busy    = (state != IDLE) | out_valid;
    end

    // Output slot: loads on acceptance, empties when the engine takes the beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (mtf_acc) begin
            out_valid <= 1'b1;
            out_data  <= mtf_data;
            out_last  <= mtf_last;
            out_src   <= 1'b0;
        end else if (dbg_acc) begin
            out_valid <= 1'b1;
            out_data  <= dbg_data;
            out_last  <= dbg_last;
            out_src   <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Debug enable is only observed at arbitration time (IDLE and the cycle entering it)
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_en_q <= 1'b0;
        end else if ((state == IDLE) || mtf_end || dbg_end) begin
            dbg_en_q <= sw_dbg_en;
        end
    end

    // Round-robin history and saturating frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last    <= 1'b1;
            mtf_frames <= '0;
            dbg_frames <= '0;
        end else begin
            if (mtf_end) begin
                rr_last <= 1'b0;
                if (mtf_frames != CNT_MAX) begin
                    mtf_frames <= mtf_frames + CNT_W'(1);
                end
            end
            if (dbg_end) begin
                rr_last <= 1'b1;
                if (dbg_frames != CNT_MAX) begin
                    dbg_frames <= dbg_frames + CNT_W'(1);
                end
            end
        end
    end

`ifdef LZ_ARB_STALL_CNT_EN
    // Backpressure cycle counter and mid-frame starvation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    always_comb begin
        frame_hold = ((state == GNT_MTF) & ~mtf_valid) | ((state == GNT_DBG) & ~dbg_valid);
    end
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_lz_sym_arb.sv
// Directed bench for cr_xp10_decomp_lz_sym_arb (CNT_W=4); stall checks build with LZ_ARB_STALL_CNT_EN.
module tb_cr_xp10_decomp_lz_sym_arb;

    localparam int unsigned SYM_W = 64;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sw_dbg_en;
    logic             mtf_valid;
    logic [SYM_W-1:0] mtf_data;
    logic             mtf_last;
    logic             mtf_ready;
    logic             dbg_valid;
    logic [SYM_W-1:0] dbg_data;
    logic             dbg_last;
    logic             dbg_ready;
    logic             out_valid;
    logic [SYM_W-1:0] out_data;
    logic             out_last;
    logic             out_src;
    logic             out_ready;
    logic [CNT_W-1:0] mtf_frames;
    logic [CNT_W-1:0] dbg_frames;
    logic             busy;
`ifdef LZ_ARB_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic             frame_hold;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [65:0] beats[$];
    logic [65:0] exp_beats[$];

    cr_xp10_decomp_lz_sym_arb #(.SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_dbg_en    (sw_dbg_en),
        .mtf_valid    (mtf_valid),
        .mtf_data     (mtf_data),
        .mtf_last     (mtf_last),
        .mtf_ready    (mtf_ready),
        .dbg_valid    (dbg_valid),
        .dbg_data     (dbg_data),
        .dbg_last     (dbg_last),
        .dbg_ready    (dbg_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_src      (out_src),
        .out_ready    (out_ready),
        .mtf_frames   (mtf_frames),
        .dbg_frames   (dbg_frames),
`ifdef LZ_ARB_STALL_CNT_EN
        .stall_cycles (stall_cycles),
        .frame_hold   (frame_hold),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Log every beat the LZ77 side takes: {src, last, data}
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            beats.push_back({out_src, out_last, out_data});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        beats.delete();
    endtask

    task automatic expect_frame(input bit src, input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            exp_beats.push_back({src, (i == n - 1), base + 64'(i)});
        end
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_count"}, 64'(beats.size()), 64'(exp_beats.size()));
        for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
            check({tag, "_data"}, beats[i][63:0], exp_beats[i][63:0]);
            check({tag, "_src_last"}, 64'(beats[i][65:64]), 64'(exp_beats[i][65:64]));
        end
        beats.delete();
        exp_beats.delete();
    endtask

    // Drive one frame from a source, holding each beat until its ready is seen
    task automatic send(input bit src, input int n, input logic [63:0] base);
        bit hs;
        int t;
        for (int i = 0; i < n; i++) begin
            if (src) begin
                dbg_valid = 1'b1;
                dbg_data  = base + 64'(i);
                dbg_last  = (i == n - 1);
            end else begin
                mtf_valid = 1'b1;
                mtf_data  = base + 64'(i);
                mtf_last  = (i == n - 1);
            end
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 400) begin
                @(negedge clk);
                hs = src ? dbg_ready : mtf_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!hs) begin
                check(src ? "dbg_ready_timeout" : "mtf_ready_timeout", 64'(hs), 64'd1);
                if (src) dbg_valid = 1'b0; else mtf_valid = 1'b0;
                return;
            end
        end
        if (src) dbg_valid = 1'b0; else mtf_valid = 1'b0;
    endtask

    initial begin
        bit          seen;
        logic [63:0] held;

        rst = 1'b1; sw_dbg_en = 1'b1; out_ready = 1'b1;
        mtf_valid = 1'b0; mtf_data = '0; mtf_last = 1'b0;
        dbg_valid = 1'b0; dbg_data = '0; dbg_last = 1'b0;
        do_reset();

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mtf_frames", 64'(mtf_frames), 64'd0);
        check("rst_dbg_frames", 64'(dbg_frames), 64'd0);
        check("rst_readies", 64'({mtf_ready, dbg_ready}), 64'd0);
`ifdef LZ_ARB_STALL_CNT_EN
        check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
`endif

        // MTF-only 4-beat frame: one grant bubble, then one beat per cycle
        mtf_valid = 1'b1; mtf_data = 64'h1000; mtf_last = 1'b0;
        step();
        check("t1_grant_ready", 64'(mtf_ready), 64'd1);
        check("t1_bubble_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_out_valid", 64'(out_valid), 64'd1);
            check("t1_out_data", out_data, 64'h1000 + 64'(i));
            check("t1_out_last", 64'(out_last), 64'(i == 3));
            check("t1_out_src", 64'(out_src), 64'd0);
            if (i < 3) begin
                mtf_data = 64'h1000 + 64'(i + 1);
                mtf_last = (i + 1 == 3);
            end else begin
                mtf_valid = 1'b0;
            end
        end
        check("t1_mtf_frames", 64'(mtf_frames), 64'd1);
        check("t1_busy_last_beat", 64'(busy), 64'd1);
        step();
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_out_valid_after", 64'(out_valid), 64'd0);
        beats.delete();

        // Contention from reset: MTF first, then strict alternation
        do_reset();
        fork
            begin send(1'b0, 3, 64'h2000); send(1'b0, 3, 64'h2003); end
            begin send(1'b1, 2, 64'h2100); send(1'b1, 2, 64'h2102); end
        join
        repeat (2) step();
        expect_frame(1'b0, 3, 64'h2000);
        expect_frame(1'b1, 2, 64'h2100);
        expect_frame(1'b0, 3, 64'h2003);
        expect_frame(1'b1, 2, 64'h2102);
        check_beats("t2_rr");
        check("t2_mtf_frames", 64'(mtf_frames), 64'd2);
        check("t2_dbg_frames", 64'(dbg_frames), 64'd2);

        // Backpressure 1,0,0,1 in the middle of a 5-beat MTF frame
        fork
            send(1'b0, 5, 64'h3000);
            begin
                repeat (3) step();
                out_ready = 1'b0;
                held = out_data;
                check("t3_held_value", held, 64'h3001);
                repeat (2) begin
                    @(negedge clk);
                    check("t3_stall_mtf_ready", 64'(mtf_ready), 64'd0);
                    check("t3_stall_out_valid", 64'(out_valid), 64'd1);
                    check("t3_stall_out_data", out_data, held);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (2) step();
        expect_frame(1'b0, 5, 64'h3000);
        check_beats("t3_bp");

        // Debug disabled: held debug request never granted while MTF frames flow
        sw_dbg_en = 1'b0;
        do_reset();
        seen = 1'b0;
        fork
            send(1'b1, 2, 64'h4100);
            begin send(1'b0, 2, 64'h4000); send(1'b0, 2, 64'h4002); send(1'b0, 2, 64'h4004); end
            begin
                repeat (100) begin
                    @(negedge clk);
                    if (dbg_ready) seen = 1'b1;
                    @(posedge clk);
                    #1;
                end
                check("t4_dbg_blocked", 64'(seen), 64'd0);
                check("t4_mtf_frames_blocked", 64'(mtf_frames), 64'd3);
                sw_dbg_en = 1'b1;
            end
        join
        repeat (2) step();
        expect_frame(1'b0, 2, 64'h4000);
        expect_frame(1'b0, 2, 64'h4002);
        expect_frame(1'b0, 2, 64'h4004);
        expect_frame(1'b1, 2, 64'h4100);
        check_beats("t4_dbg_en");
        check("t4_dbg_frames", 64'(dbg_frames), 64'd1);

        // Reset on beat 2 of a 5-beat frame drops it and clears counters
        mtf_valid = 1'b1; mtf_data = 64'h5000; mtf_last = 1'b0;
        step();
        step();
        mtf_data = 64'h5001;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mtf_valid = 1'b0;
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_mtf_frames", 64'(mtf_frames), 64'd0);
        check("t5_dbg_frames", 64'(dbg_frames), 64'd0);
        check("t5_busy_idle", 64'(busy), 64'd0);
        check("t5_mtf_ready_idle", 64'(mtf_ready), 64'd0);
        beats.delete();
        send(1'b0, 2, 64'h5100);
        repeat (2) step();
        expect_frame(1'b0, 2, 64'h5100);
        check_beats("t5_after_rst");
        check("t5_mtf_frames_after", 64'(mtf_frames), 64'd1);

        // Saturation: 19 single-beat frames on a 4-bit counter
        do_reset();
        for (int i = 0; i < 19; i++) begin
            send(1'b0, 1, 64'h6000 + 64'(i));
            if (i == 13) check("t6_frames_14", 64'(mtf_frames), 64'd14);
            if (i == 14) check("t6_frames_15", 64'(mtf_frames), 64'd15);
        end
        check("t6_frames_sat", 64'(mtf_frames), 64'd15);
        check("t6_dbg_frames", 64'(dbg_frames), 64'd0);
        repeat (2) step();
        beats.delete();

`ifdef LZ_ARB_STALL_CNT_EN
        // Seven backpressured cycles with a starving requester mid-frame
        do_reset();
        out_ready = 1'b0;
        mtf_valid = 1'b1; mtf_data = 64'h7000; mtf_last = 1'b0;
        step();
        step();
        mtf_valid = 1'b0;
        #1;
        check("t7_frame_hold_on", 64'(frame_hold), 64'd1);
        repeat (7) step();
        check("t7_stall_cycles", 64'(stall_cycles), 64'd7);
        mtf_valid = 1'b1; mtf_data = 64'h7001; mtf_last = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t7_frame_hold_off", 64'(frame_hold), 64'd0);
        step();
        mtf_valid = 1'b0;
        repeat (2) step();
        check("t7_stall_final", 64'(stall_cycles), 64'd7);
        check("t7_mtf_frames", 64'(mtf_frames), 64'd1);
        expect_frame(1'b0, 2, 64'h7000);
        check_beats("t7_stall");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
